// File: rtl/bloom_scan_ctrl_if.sv
// Signal bundle between the Bloom scan sequencer, the host, block memory and the
// find_bit_pattern datapath. master = sequencer side, slave = everything it talks to.
interface bloom_scan_ctrl_if #(
    parameter int P_SIZE      = 12,
    parameter int PPB         = 64,
    parameter int NOB_WIDTH   = 6,
    parameter int B_OFS_WIDTH = 10,
    parameter int CNT_WIDTH   = 13
);
    localparam int B_SIZE = PPB * P_SIZE;

    logic                   start;
    logic                   abort;
    logic [2:0]             num_patterns;
    logic [4*P_SIZE-1:0]    pat_in;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [CNT_WIDTH-1:0]   hit_cnt;
    logic                   mem_rd;
    logic [NOB_WIDTH-1:0]   mem_addr;
    logic [B_SIZE-1:0]      mem_rdata;
    logic [B_SIZE-1:0]      dp_a;
    logic [NOB_WIDTH:0]     dp_b_idx;
    logic [4*P_SIZE-1:0]    dp_pat;
    logic [2:0]             dp_num_patterns;
    logic                   dp_put;
    logic                   dp_rst_n;
    logic [B_OFS_WIDTH-1:0] dp_tpn_ofs;

    modport master (
        input  start, abort, num_patterns, pat_in, mem_rdata, dp_tpn_ofs,
        output busy, done, err, hit_cnt, mem_rd, mem_addr,
               dp_a, dp_b_idx, dp_pat, dp_num_patterns, dp_put, dp_rst_n
    );

    modport slave (
        output start, abort, num_patterns, pat_in, mem_rdata, dp_tpn_ofs,
        input  busy, done, err, hit_cnt, mem_rd, mem_addr,
               dp_a, dp_b_idx, dp_pat, dp_num_patterns, dp_put, dp_rst_n
    );
endinterface

// File: rtl/bloom_scan_ctrl.sv
// Scan sequencer for the Bloom-filter page-pattern datapath: walks all blocks in
// 5-cycle slots (RD, LAT, CMP, CAP, PUT) and totals the true pages it reports.
module bloom_scan_ctrl #(
    parameter int NOB         = 64,
    parameter int P_SIZE      = 12,
    parameter int NOB_WIDTH   = 6,
    parameter int B_OFS_WIDTH = 10,
    parameter int CNT_WIDTH   = 13
) (
    input  logic              clk,
    input  logic              rst,
    bloom_scan_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RD, S_LAT, S_CMP, S_CAP, S_PUT, S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 clr_q;
    logic [NOB_WIDTH-1:0] blk;
    logic                 np_bad;
    logic                 last_blk;

    // The datapath offset is always a whole number of pages, so the quotient is exact.
    function automatic logic [CNT_WIDTH-1:0] ofs_to_pages(input logic [B_OFS_WIDTH-1:0] ofs);
        logic [B_OFS_WIDTH-1:0] q;
        q = ofs / B_OFS_WIDTH'(P_SIZE);
        return CNT_WIDTH'(q);
    endfunction

    assign np_bad   = (bus.num_patterns == 3'd0) || (bus.num_patterns > 3'd4);
    assign last_blk = (blk == NOB_WIDTH'(NOB - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start && !bus.abort) state_d = S_LOAD;
            S_LOAD: state_d = np_bad ? S_DONE : S_RD;
            S_RD:   state_d = S_LAT;
            S_LAT:  state_d = S_CMP;
            S_CMP:  state_d = S_CAP;
            S_CAP:  state_d = S_PUT;
            S_PUT:  state_d = last_blk ? S_DONE : S_RD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;
    end

    // Strobes are registered off the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.mem_rd <= 1'b0;
            bus.dp_put <= 1'b0;
            clr_q      <= 1'b1;
        end else begin
            bus.busy   <= (state_d != S_IDLE) && (state_d != S_DONE);
            bus.done   <= (state_d == S_DONE);
            bus.mem_rd <= (state_d == S_RD);
            bus.dp_put <= (state_d == S_PUT);
            clr_q      <= (state_d != S_LOAD);
        end
    end

    // Block data, pattern set and running count: written only in LOAD, LAT and PUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.err             <= 1'b0;
            bus.hit_cnt         <= '0;
            bus.dp_a            <= '0;
            bus.dp_b_idx        <= '0;
            bus.dp_pat          <= '0;
            bus.dp_num_patterns <= '0;
            blk                 <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    bus.dp_pat          <= bus.pat_in;
                    bus.dp_num_patterns <= bus.num_patterns;
                    bus.err             <= np_bad;
                    bus.hit_cnt         <= '0;
                    blk                 <= '0;
                end
                S_LAT: begin
                    bus.dp_a     <= bus.mem_rdata;
                    bus.dp_b_idx <= {1'b0, blk};
                end
                S_PUT: begin
                    bus.hit_cnt <= bus.hit_cnt + ofs_to_pages(bus.dp_tpn_ofs);
                    blk         <= blk + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr = blk;
    assign bus.dp_rst_n = rst & clr_q;
endmodule

// File: tb/tb_bloom_scan_ctrl.sv
// Directed bench for bloom_scan_ctrl with a block-memory model and a behavioural
// page-match datapath that reports 12 * (matching pages) per block.
module tb_bloom_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bloom_scan_ctrl_if bus ();

    bloom_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [767:0] mem [64];

    always_ff @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic int count_match(input logic [767:0] a, input logic [47:0] p,
                                       input logic [2:0] np);
        int c;
        bit hit;
        c = 0;
        for (int pg = 0; pg < 64; pg++) begin
            hit = 1'b0;
            for (int k = 0; k < 4; k++)
                if (k < int'(np) && a[pg*12 +: 12] == p[k*12 +: 12]) hit = 1'b1;
            if (hit) c++;
        end
        return c;
    endfunction

    always_comb bus.dp_tpn_ofs = 10'(12 * count_match(bus.dp_a, bus.dp_pat, bus.dp_num_patterns));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int mode, input logic [11:0] val);
        for (int b = 0; b < 64; b++) begin
            mem[b] = '0;
            for (int p = 0; p < 64; p++) begin
                if (mode == 1 || (mode == 2 && p < b)) mem[b][p*12 +: 12] = val;
            end
        end
        if (mode == 0) mem[2][2*12 +: 12] = val;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},     64'(bus.busy), 64'd0);
        chk({tag, "_done"},     64'(bus.done), 64'd0);
        chk({tag, "_err"},      64'(bus.err), 64'd0);
        chk({tag, "_mem_rd"},   64'(bus.mem_rd), 64'd0);
        chk({tag, "_dp_put"},   64'(bus.dp_put), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        chk({tag, "_hit_cnt"},  64'(bus.hit_cnt), 64'd0);
        chk({tag, "_dp_a_zero"}, 64'(bus.dp_a == '0), 64'd1);
        chk({tag, "_dp_b_idx"}, 64'(bus.dp_b_idx), 64'd0);
        chk({tag, "_dp_pat"},   64'(bus.dp_pat), 64'd0);
        chk({tag, "_dp_np"},    64'(bus.dp_num_patterns), 64'd0);
        chk({tag, "_dp_rst_n"}, 64'(bus.dp_rst_n), 64'd0);
    endtask

    int r_done_first, r_done_last, r_done_cnt, r_put_cnt, r_rd_cnt, r_busy_cnt;
    int r_nz_cnt, r_nz_blk, r_space_bad, r_rst_low_cnt, r_rst_low_first, r_rst_low_last;
    int r_hit_c2;
    logic r_busy_after;

    // start is raised before edge E0; cycle n is sampled on the falling edge after En-1.
    task automatic run_scan(input int off_cyc, input int abort_cyc, input int max_cyc);
        int last_put;
        r_done_first = -1; r_done_last = -1; r_done_cnt = 0; r_put_cnt = 0; r_rd_cnt = 0;
        r_busy_cnt = 0; r_nz_cnt = 0; r_nz_blk = -1; r_space_bad = 0; r_rst_low_cnt = 0;
        r_rst_low_first = -1; r_rst_low_last = -1; r_hit_c2 = -1; r_busy_after = 1'bx;
        last_put = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            if (n >= off_cyc) bus.start = 1'b0;
            bus.abort = (n == abort_cyc);
            if (bus.done) begin
                r_done_cnt++;
                if (r_done_first < 0) r_done_first = n;
                r_done_last = n;
                last_put = 0;
            end
            if (bus.dp_put) begin
                r_put_cnt++;
                if (last_put != 0 && n - last_put != 5) r_space_bad++;
                last_put = n;
                if (bus.dp_tpn_ofs != 0) begin
                    r_nz_cnt++;
                    r_nz_blk = int'(bus.dp_b_idx);
                end
            end
            if (bus.mem_rd) r_rd_cnt++;
            if (bus.busy) r_busy_cnt++;
            if (!bus.dp_rst_n) begin
                r_rst_low_cnt++;
                if (r_rst_low_first < 0) r_rst_low_first = n;
                r_rst_low_last = n;
            end
            if (n == 2) r_hit_c2 = int'(bus.hit_cnt);
            if (n == abort_cyc + 1) r_busy_after = bus.busy;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  np;
        logic [47:0] pats;
        int          fill;
        logic [11:0] fval;
        int          exp_hit;
        int          exp_err;
        int          exp_done;
        int          exp_puts;
        int          exp_nz;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{3'd1, 48'h000_000_000_ABC, 0, 12'hABC, 1,    0, 322, 64, 1};
        tbl[1] = '{3'd0, 48'h123_456_789_ABC, 0, 12'hABC, 0,    1, 2,   0,  0};
        tbl[2] = '{3'd5, 48'h123_456_789_ABC, 0, 12'hABC, 0,    1, 2,   0,  0};
        tbl[3] = '{3'd4, 48'h123_5A5_111_222, 1, 12'h5A5, 4096, 0, 322, 64, 64};
        tbl[4] = '{3'd2, 48'h000_000_321_0F0, 2, 12'h321, 2016, 0, 322, 64, 63};
        tbl[5] = '{3'd3, 48'hABC_777_666_555, 1, 12'hABC, 0,    0, 322, 64, 0};
        tbl[6] = '{3'd7, 48'h000_000_000_ABC, 0, 12'hABC, 0,    1, 2,   0,  0};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_patterns = 3'd0;
        bus.pat_in = '0;
        fill_mem(0, 12'h000);

        #22;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            bus.num_patterns = tbl[i].np;
            bus.pat_in = tbl[i].pats;
            fill_mem(tbl[i].fill, tbl[i].fval);
            run_scan(1, 0, 330);
            chk($sformatf("v%0d_hit_cnt", i),   64'(bus.hit_cnt), 64'(tbl[i].exp_hit));
            chk($sformatf("v%0d_err", i),       64'(bus.err), 64'(tbl[i].exp_err));
            chk($sformatf("v%0d_done_cyc", i),  64'(r_done_first), 64'(tbl[i].exp_done));
            chk($sformatf("v%0d_done_cnt", i),  64'(r_done_cnt), 64'd1);
            chk($sformatf("v%0d_puts", i),      64'(r_put_cnt), 64'(tbl[i].exp_puts));
            chk($sformatf("v%0d_mem_rds", i),   64'(r_rd_cnt), 64'(tbl[i].exp_puts));
            chk($sformatf("v%0d_nz_puts", i),   64'(r_nz_cnt), 64'(tbl[i].exp_nz));
            chk($sformatf("v%0d_put_space", i), 64'(r_space_bad), 64'd0);
            chk($sformatf("v%0d_busy_cyc", i),  64'(r_busy_cnt), 64'(tbl[i].exp_err ? 1 : 321));
            chk($sformatf("v%0d_clr_cyc", i),   64'(r_rst_low_first), 64'd1);
            chk($sformatf("v%0d_clr_cnt", i),   64'(r_rst_low_cnt), 64'd1);
            chk($sformatf("v%0d_dp_pat", i),    64'(bus.dp_pat), 64'(tbl[i].pats));
            chk($sformatf("v%0d_dp_np", i),     64'(bus.dp_num_patterns), 64'(tbl[i].np));
            if (tbl[i].exp_nz == 1) chk($sformatf("v%0d_nz_blk", i), 64'(r_nz_blk), 64'd2);
        end

        // Abort in block 10's CMP cycle, then a clean rescan.
        bus.num_patterns = 3'd1;
        bus.pat_in = 48'h000_000_000_ABC;
        fill_mem(0, 12'hABC);
        run_scan(1, 54, 120);
        chk("abort_busy55",  64'(r_busy_after), 64'd0);
        chk("abort_no_done", 64'(r_done_cnt), 64'd0);
        chk("abort_puts",    64'(r_put_cnt), 64'd10);
        chk("abort_busy_cyc", 64'(r_busy_cnt), 64'd54);
        chk("abort_hit_hold", 64'(bus.hit_cnt), 64'd1);
        run_scan(1, 0, 330);
        chk("rescan_hit_c2", 64'(r_hit_c2), 64'd0);
        chk("rescan_done",   64'(r_done_first), 64'd322);
        chk("rescan_hit",    64'(bus.hit_cnt), 64'd1);

        // start held through the scan and DONE: restart only once seen in IDLE.
        run_scan(324, 0, 660);
        chk("hold_done1",     64'(r_done_first), 64'd322);
        chk("hold_done2",     64'(r_done_last), 64'd645);
        chk("hold_done_cnt",  64'(r_done_cnt), 64'd2);
        chk("hold_clr_first", 64'(r_rst_low_first), 64'd1);
        chk("hold_clr_last",  64'(r_rst_low_last), 64'd324);
        chk("hold_clr_cnt",   64'(r_rst_low_cnt), 64'd2);
        chk("hold_puts",      64'(r_put_cnt), 64'd128);
        chk("hold_busy_cyc",  64'(r_busy_cnt), 64'd642);

        // Asynchronous reset in cycle 100, checked while the clock is still low.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        chk("arst_busy_before", 64'(bus.busy), 64'd1);
        #1 rst = 1'b0;
        #1 check_reset_vals("arst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_idle_busy", 64'(bus.busy), 64'd0);
        chk("arst_idle_done", 64'(bus.done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bloom_scan_ctrl.md
# bloom_scan_ctrl

Sequencer for the Bloom-filter page-pattern datapath (`find_bit_pattern`). On `start` it performs these steps:
- latches up to four 12-bit patterns and the pattern count;
- clears the datapath;
- streams all 64 blocks of 768 bits from block memory into the datapath, one block per 5-cycle slot;
- pulses the global-array commit strobe once per block;
- accumulates the total true-page count, then reports `done`.

It sits between the host/FTL command interface and the comparator datapath.

## Interface
- NOB, 64, number of blocks per scan
- PPB, 64, pages per block
- P_SIZE, 12, bits per page/pattern
- B_SIZE, 768, bits per block (PPB*P_SIZE)
- NOB_WIDTH, 6, block-index width
- B_OFS_WIDTH, 10, width of datapath true-page bit offset
- CNT_WIDTH, 13, hit counter width (0..4096)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin scan; sampled only in IDLE
- abort  in  1  cancel scan; sampled in any non-IDLE state
- num_patterns  in  3  valid values 1..4
- pat_in  in  4*P_SIZE  patterns x1..x4, with x1 = [11:0]
- busy  out  1  high from LOAD through the last PUT
- done  out  1  one-cycle pulse in DONE
- err  out  1  invalid num_patterns; held until next accepted start
- hit_cnt  out  CNT_WIDTH  true pages found in current/last scan
- mem_rd  out  1  block read request
- mem_addr  out  NOB_WIDTH  block index to read
- mem_rdata  in  B_SIZE  valid exactly one cycle after mem_rd
- dp_a  out  B_SIZE  registered block data to datapath
- dp_b_idx  out  NOB_WIDTH+1  registered block index, MSB always 0
- dp_pat  out  4*P_SIZE  registered patterns
- dp_num_patterns  out  3  registered pattern count
- dp_put  out  1  registered commit strobe, one cycle high per block
- dp_rst_n  out  1  datapath clear: rst AND registered clear bit
- dp_tpn_ofs  in  B_OFS_WIDTH  datapath per-block true-page bit offset

## Operation
States: IDLE, LOAD, RD, LAT, CMP, CAP, PUT, DONE. Block counter `blk` is 6 bits.

- **IDLE:**
  - start=1 and abort=0 → LOAD.
  - abort wins over a simultaneous start.
- **LOAD (1 cycle):**
  - latches pat_in→dp_pat and num_patterns→dp_num_patterns;
  - sets blk=0, hit_cnt=0, err=0;
  - clear bit low, so dp_rst_n=0 for this cycle only;
  - num_patterns ∉ {1..4} → err=1, go to DONE (no mem_rd, no dp_put); otherwise → RD.
- **RD:** mem_rd=1, mem_addr=blk → LAT.
- **LAT:** dp_a←mem_rdata, dp_b_idx←{0,blk} at end of cycle → CMP.
- **CMP:** dp_a is stable; the datapath registers its per-block result at the end of this cycle → CAP.
- **CAP:** guard cycle so dp_put never rises on the same edge the datapath result updates → PUT.
- **PUT:**
  - dp_put=1;
  - hit_cnt += dp_tpn_ofs/12, an exact division because the offset is always a multiple of 12, giving 0..64 per block;
  - blk==NOB-1 → DONE; else blk+1, → RD.
- **DONE (1 cycle):** done=1, busy=0 → IDLE. hit_cnt and err hold until the next LOAD.
- **abort in any state LOAD..PUT:**
  - next state is IDLE;
  - dp_put/mem_rd forced 0 next cycle;
  - no done pulse; hit_cnt holds its partial value.
- **start while not IDLE:** ignored.
- **start in a DONE cycle:** ignored; must be re-asserted in IDLE.
- dp_a, dp_b_idx, dp_pat, dp_num_patterns change only in LOAD/LAT; they are stable during CMP/CAP/PUT.
- **hit_cnt saturation:** max reachable value is 4096, which fits 13 bits, so no wrap is possible.

## Timing
- **Reset values (rst low):**
  - state=IDLE;
  - busy, done, err, mem_rd, dp_put = 0;
  - mem_addr, dp_a, dp_b_idx, dp_pat, dp_num_patterns, hit_cnt, blk = 0;
  - clear bit = 1; dp_rst_n=0 while rst low.
- **Reset mid-scan:** the asynchronous reset returns everything to the reset values immediately; there is no done pulse.
- **Cycle numbering:** start is sampled at edge E0, and cycle n is the cycle following edge En-1.
  - LOAD is cycle 1.
  - Block b occupies cycles 2+5b..6+5b; its dp_put is in cycle 6+5b.
  - DONE is cycle 322, so done rises 322 cycles after the start edge.
  - busy is high in cycles 1..321.
- **Invalid num_patterns:** LOAD at cycle 1, DONE with err=1 at cycle 2.
- **Throughput:** one block per 5 cycles; 64 dp_put pulses per completed scan, each exactly 1 cycle wide, spaced 5 cycles apart.

## Test plan
- **Single match:** num_patterns=1, x1=12'hABC, only page 130 (block 2, slot 2) = ABC → 64 dp_put pulses; hit_cnt=1; done at cycle 322; dp_tpn_ofs=12 seen only in block 2's PUT.
- **Invalid count:** num_patterns=0 (repeat with 5) → err=1 with done at cycle 2; mem_rd and dp_put never asserted; hit_cnt=0.
- **All match:** all pages = x3, num_patterns=4 → hit_cnt=4096, no overflow; err=0.
- **Abort mid-scan:** assert abort in block 10's CMP cycle (cycle 54) → busy=0 at cycle 55; no done; exactly 10 dp_put pulses; a new start runs a full 322-cycle scan with hit_cnt restarted at 0.
- **Async reset mid-scan:** rst low in cycle 100 → all outputs reach reset values without a clock edge; dp_rst_n=0 while rst is low.
- **Ignored start:** start held high during a scan and during the DONE cycle → no restart; a second scan begins only when start is seen in IDLE; dp_rst_n low exactly in its LOAD cycle.
